// File: rtl/joybus_rx_decoder.sv
// -----------------------------------------------------------------------------
// joybus_rx_decoder
//
// Purpose:
//   Decodes the receive side of a GameCube joybus line. The edge detector
//   upstream provides a 3-cycle pulse per line transition plus the
//   synchronized line level. This block times each low phase and turns it
//   into a bit (short low = 1, long low = 0). It assembles bits MSB-first
//   into bytes and signals end-of-frame once the line has been idle high long
//   enough.
//
// Ports:
//   pclk        in   1  system clock
//   presetn     in   1  asynchronous active-low reset
//   edges       in   1  edge pulse, 3 cycles high per line transition
//   line_s      in   1  synchronized line level, aligned with edges
//   rx_data     out  8  last completed byte
//   rx_valid    out  1  1-cycle strobe, rx_data updated this cycle
//   frame_done  out  1  1-cycle strobe on idle timeout
//   frame_err   out  1  qualifies frame_done: bad stop/residual bits or stuck low
//   busy        out  1  high from the first falling edge until frame_done
//
// Configuration macro:
//   JOYBUS_RX_GLITCH_FILT_EN  when defined, a low phase shorter than GLITCH_CYC
//                             is discarded as a glitch. The idle counter then
//                             resumes from the value it held before the glitch.
// -----------------------------------------------------------------------------
module joybus_rx_decoder #(
  parameter int unsigned BIT_THRESH   = 200,
  parameter int unsigned LOW_MAX      = 600,
  parameter int unsigned IDLE_TIMEOUT = 500,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned GLITCH_CYC   = 20
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       edges,
  input  logic       line_s,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BIT_THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] LOW_MAX_C    = CNT_W'(LOW_MAX);
  localparam logic [CNT_W-1:0] IDLE_LAST_C  = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_STUCK
  } state_t;

  state_t             state_q, state_d;
  logic               edges_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               err_q, err_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;

  logic               ev, fall, rise;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         shift_new;

`ifdef JOYBUS_RX_GLITCH_FILT_EN
  localparam logic [CNT_W-1:0] GLITCH_CYC_C = CNT_W'(GLITCH_CYC);
  // High-phase count captured when a low phase starts, restored on a glitch.
  logic [CNT_W-1:0]   hold_q, hold_d;
`else
  // GLITCH_CYC only matters when the glitch filter is built in.
  logic               glitch_cyc_unused;
  assign glitch_cyc_unused = ^GLITCH_CYC;
`endif

  // Only the first cycle of each 3-cycle pulse is an event.
  assign ev   = edges & ~edges_q;
  assign fall = ev & ~line_s;
  assign rise = ev & line_s;

  // cnt_inc is the number of cycles elapsed in the current phase including
  // this one, so on the rise it equals the low width in cycles.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign shift_new = {shift_q[6:0], (cnt_inc < BIT_THRESH_C)};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    err_d        = err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
`ifdef JOYBUS_RX_GLITCH_FILT_EN
    hold_d       = hold_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef JOYBUS_RX_GLITCH_FILT_EN
          hold_d  = '0;
`endif
        end
      end

      ST_LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d = ST_HIGH;
`ifdef JOYBUS_RX_GLITCH_FILT_EN
          if (cnt_inc < GLITCH_CYC_C) begin
            cnt_d = hold_q;
          end else
`endif
          begin
            cnt_d     = '0;
            shift_d   = shift_new;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = shift_new;
              rx_valid_d = 1'b1;
            end
          end
        end else if (cnt_inc == LOW_MAX_C) begin
          err_d   = 1'b1;
          state_d = ST_STUCK;
        end
      end

      ST_HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          state_d = ST_LOW;
          cnt_d   = '0;
`ifdef JOYBUS_RX_GLITCH_FILT_EN
          hold_d  = cnt_q;
`endif
        end else if (cnt_q == IDLE_LAST_C) begin
          // A valid frame leaves exactly one residual bit, the stop bit = 1.
          frame_done_d = 1'b1;
          frame_err_d  = err_q | (bit_cnt_q != 3'd1) | ~shift_q[0];
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          err_d        = 1'b0;
          bit_cnt_d    = '0;
          shift_d      = '0;
          cnt_d        = '0;
        end
      end

      ST_STUCK: begin
        // The bit is lost; just resynchronise on the next rise.
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= ST_IDLE;
      edges_q      <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      err_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef JOYBUS_RX_GLITCH_FILT_EN
      hold_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      edges_q      <= edges;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      err_q        <= err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef JOYBUS_RX_GLITCH_FILT_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_joybus_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_joybus_rx_decoder
//
// Drives joybus-style line transitions (3-cycle edge pulse plus level) into
// joybus_rx_decoder. Expected bytes and frame ends are queued as stimulus is
// issued. A monitor pops the queue on every rx_valid / frame_done and checks
// the payload and the latency from the most recent rising line edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_joybus_rx_decoder;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       edges = 1'b0;
  logic       line_s = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  always #5 pclk = ~pclk;

  joybus_rx_decoder dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .edges      (edges),
    .line_s     (line_s),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    bit         is_frame;
    logic [7:0] data;
    bit         err;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise = 0;
  logic edges_p = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycle counter and the cycle of the last rising line edge (first pulse cycle).
  always @(posedge pclk) begin
    cyc     <= cyc + 1;
    edges_p <= edges;
    if (edges && !edges_p && line_s) last_rise <= cyc + 1;
  end

  // Monitor: one popped expectation per DUT output strobe.
  always @(negedge pclk) begin
    if (rx_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rx_valid: rx_data=0x%02h with no event expected", rx_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("kind_is_frame_at_rx_valid", int'(mon_e.is_frame), 0);
        check("rx_data", int'(rx_data), int'(mon_e.data));
        check("rx_valid_latency", cyc - last_rise, mon_e.lat);
        $display("rx_valid  rx_data=0x%02h expected=0x%02h cyc=%0d", rx_data, mon_e.data, cyc);
      end
    end
    if (frame_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_frame_done: frame_err=%0b with no event expected", frame_err);
      end else begin
        mon_e = sb_q.pop_front();
        check("kind_is_frame_at_frame_done", int'(mon_e.is_frame), 1);
        check("frame_err", int'(frame_err), int'(mon_e.err));
        check("frame_done_latency", cyc - last_rise, mon_e.lat);
        $display("frame_done frame_err=%0b expected=%0b latency=%0d", frame_err, mon_e.err,
                 cyc - last_rise);
      end
    end
  end

  // One line transition at a negedge; w cycles until the next transition.
  task automatic phase(input logic lvl, input int w);
    line_s = lvl;
    edges  = 1'b1;
    repeat (3) @(negedge pclk);
    edges  = 1'b0;
    repeat (w - 3) @(negedge pclk);
  endtask

  task automatic send_bit(input logic b, input int hi);
    phase(1'b0, b ? 100 : 300);
    phase(1'b1, hi);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], b[i] ? 300 : 100);
  endtask

  // Stop bit followed by a long idle high phase.
  task automatic send_stop();
    phase(1'b0, 100);
    phase(1'b1, 700);
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_t e;
    e.is_frame = 1'b0;
    e.data     = d;
    e.err      = 1'b0;
    e.lat      = 0;
    sb_q.push_back(e);
  endtask

  task automatic push_frame(input bit err, input int lat);
    exp_t e;
    e.is_frame = 1'b1;
    e.data     = 8'h00;
    e.err      = err;
    e.lat      = lat;
    sb_q.push_back(e);
  endtask

  initial begin
    presetn = 1'b0;
    edges   = 1'b0;
    line_s  = 1'b1;
    repeat (3) @(negedge pclk);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);

    // 1: single byte 0x00 plus stop
    push_byte(8'h00);
    push_frame(1'b0, 500);
    send_byte(8'h00);
    send_stop();
    check("busy_after_frame1", int'(busy), 0);

    // 2: poll command 0x40 0x03 0x00 plus stop
    push_byte(8'h40);
    push_byte(8'h03);
    push_byte(8'h00);
    push_frame(1'b0, 500);
    send_byte(8'h40);
    send_byte(8'h03);
    send_byte(8'h00);
    send_stop();

    // 3: line stuck low for 700 cycles
    push_frame(1'b1, 500);
    phase(1'b0, 700);
    phase(1'b1, 700);

    // 4: five bits then idle, then a clean frame
    push_frame(1'b1, 500);
    send_bit(1'b1, 300);
    send_bit(1'b0, 100);
    send_bit(1'b1, 300);
    send_bit(1'b1, 300);
    check("busy_mid_frame", int'(busy), 1);
    send_bit(1'b0, 700);
    check("busy_after_partial", int'(busy), 0);
    push_byte(8'h5A);
    push_frame(1'b0, 500);
    send_byte(8'h5A);
    send_stop();

    // 5: low widths 199 -> 1 and 200 -> 0, then 1,0,0,0,0,1 -> 0xA1
    push_byte(8'hA1);
    push_frame(1'b0, 500);
    phase(1'b0, 199);
    phase(1'b1, 100);
    phase(1'b0, 200);
    phase(1'b1, 100);
    send_bit(1'b1, 300);
    send_bit(1'b0, 100);
    send_bit(1'b0, 100);
    send_bit(1'b0, 100);
    send_bit(1'b0, 100);
    send_bit(1'b1, 300);
    send_stop();

    // 6: reset in the middle of a byte, then a clean frame
    send_bit(1'b1, 300);
    send_bit(1'b0, 100);
    send_bit(1'b1, 300);
    send_bit(1'b1, 300);
    line_s = 1'b0;
    edges  = 1'b1;
    repeat (3) @(negedge pclk);
    edges  = 1'b0;
    repeat (20) @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_rx_data", int'(rx_data), 0);
    check("midreset_frame_done", int'(frame_done), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    check("midreset_busy", int'(busy), 0);
    line_s = 1'b1;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);
    push_byte(8'h40);
    push_frame(1'b0, 500);
    send_byte(8'h40);
    send_stop();

`ifdef JOYBUS_RX_GLITCH_FILT_EN
    // Glitch 100 cycles into the idle phase: no bit, idle count held.
    // Count at the glitch fall is 99; it resumes from 99 after the glitch
    // rise, so frame_done comes 401 cycles after that rise.
    push_byte(8'h00);
    push_frame(1'b0, 401);
    send_byte(8'h00);
    phase(1'b0, 100);
    phase(1'b1, 100);
    phase(1'b0, 10);
    phase(1'b1, 700);
`endif

    repeat (10) @(negedge pclk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
